inst_queue: RTL

- Dual-slot instruction queue between fetch and the dual-issue decode stage.
- Buffers up to DEPTH fetched instructions in program order.
- Presents the two oldest entries to decode as the inst0/inst1 f1 pair; inst0 is always older than inst1.
- Dequeues only when decode is not stalled; the whole queue is discarded on a writeback flush.

---
 rtl/inst_queue.sv | 105 ++++++++++
 1 files changed

// File: rtl/inst_queue.sv
// Dual-slot instruction queue between fetch and the dual-issue decode stage.
// Circular buffer of DEPTH entries kept in program order; the two oldest
// entries are presented to decode as the inst0/inst1 f1 pair.
module inst_queue #(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_queue_i,
  input  logic             fetch_inst0_valid_i,
  input  logic [63:0]      fetch_inst0_pc_i,
  input  logic [31:0]      fetch_inst0_inst_i,
  input  logic             fetch_inst1_valid_i,
  input  logic [63:0]      fetch_inst1_pc_i,
  input  logic [31:0]      fetch_inst1_inst_i,
  output logic             fetch_ready_o,
  input  logic             stall_decoder_inst0_i,
  output logic             inst0_f1_valid_o,
  output logic [63:0]      inst0_f1_pc_o,
  output logic [31:0]      inst0_f1_inst_o,
  output logic             inst1_f1_valid_o,
  output logic [63:0]      inst1_f1_pc_o,
  output logic [31:0]      inst1_f1_inst_o,
  output logic [PTR_W:0]   queue_count_o
);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  logic [63:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  ptr_t       head, tail;
  cnt_t       count;
  ptr_t       head_p1;
  ptr_t       slot1_idx;
  logic       enq_ok;
  logic [1:0] enq_n;
  logic [1:0] deq_n;

  assign head_p1 = head + ptr_t'(1);
  // Slot 1 lands right after slot 0, or at tail itself when slot 0 is empty.
  assign slot1_idx = tail + ptr_t'(fetch_inst0_valid_i);

  // Ready only from current occupancy; a same-cycle dequeue earns no credit.
  assign fetch_ready_o    = (count <= cnt_t'(DEPTH - 2));
  assign inst0_f1_valid_o = (count >= cnt_t'(1));
  assign inst1_f1_valid_o = (count >= cnt_t'(2));
  assign queue_count_o    = count;

  assign inst0_f1_pc_o   = inst0_f1_valid_o ? pc_mem[head]      : '0;
  assign inst0_f1_inst_o = inst0_f1_valid_o ? inst_mem[head]    : '0;
  assign inst1_f1_pc_o   = inst1_f1_valid_o ? pc_mem[head_p1]   : '0;
  assign inst1_f1_inst_o = inst1_f1_valid_o ? inst_mem[head_p1] : '0;

  // Per-cycle enqueue/dequeue amounts; flush suppresses enqueue.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    enq_ok = 1'b0;
    enq_n  = 2'd0;
    deq_n  = 2'd0;
    if (!flush_queue_i && fetch_ready_o && (fetch_inst0_valid_i || fetch_inst1_valid_i)) begin
      enq_ok = 1'b1;
      enq_n  = {1'b0, fetch_inst0_valid_i} + {1'b0, fetch_inst1_valid_i};
    end
    if (!stall_decoder_inst0_i) begin
      deq_n = {1'b0, inst0_f1_valid_o} + {1'b0, inst1_f1_valid_o};
    end
  end

  // Pointer and occupancy update; flush takes priority over enqueue/dequeue.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush_queue_i) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + ptr_t'(deq_n);
      tail  <= tail + ptr_t'(enq_n);
      count <= count + cnt_t'(enq_n) - cnt_t'(deq_n);
    end
  end

  // Entry storage writes, compacting valid fetch slots in program order.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset; count gates every read, so stale contents are never visible.
    if (enq_ok) begin
      if (fetch_inst0_valid_i) begin
        pc_mem[tail]   <= fetch_inst0_pc_i;
        inst_mem[tail] <= fetch_inst0_inst_i;
      end
      if (fetch_inst1_valid_i) begin
        pc_mem[slot1_idx]   <= fetch_inst1_pc_i;
        inst_mem[slot1_idx] <= fetch_inst1_inst_i;
      end
    end
  end

endmodule
